xnor_gate_array: RTL and testbench
==================================

Name: xnor_gate_array

Overview:
- Parameterised bitwise XNOR (equivalence) unit.
- Provides a combinational result for glue logic, plus a registered result with a valid flag and an all-bits-equal flag for pipelined compare paths.
- The 1-bit instance (WIDTH=1) is the basic gate: y = ~(a ^ b).
- Sits between operand sources and downstream match/compare logic.

Parameters:
- WIDTH, 1, operand and result width in bits; legal range 1..64.
- REG_OUT, 1, 1 = registered outputs (y_q, out_valid, all_equal) are driven from flops; 0 = they are combinational copies, and clk/rst are unused for them.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, qualifies a/b for the registered path.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- y, output, WIDTH, combinational bitwise XNOR of a and b.
- y_q, output, WIDTH, registered bitwise XNOR.
- out_valid, output, 1, y_q/all_equal hold a valid result.
- all_equal, output, 1, high when a == b for the captured operands (AND-reduce of the XNOR).
- match_count, output, $clog2(WIDTH+1), number of equal bit positions (present only with XNOR_POPCOUNT_EN).

Behaviour:
- y[i] = ~(a[i] ^ b[i]) for every bit, purely combinational.
  - y is independent of clk, rst and in_valid.
  - y settles within the same delta/timestep as input changes.
- Truth table per bit (a,b -> y): 0,0 -> 1; 0,1 -> 0; 1,0 -> 0; 1,1 -> 1.
- REG_OUT=1, at each rising clk edge:
  - If rst = 1: y_q <= 0, out_valid <= 0, all_equal <= 0, match_count <= 0.
  - Else if in_valid = 1: y_q <= XNOR(a,b), all_equal <= &XNOR(a,b), match_count <= popcount(XNOR(a,b)), out_valid <= 1.
  - Else: out_valid <= 0; y_q, all_equal and match_count hold their previous values.
- Latency, REG_OUT=1: exactly one cycle from in_valid sampled high to out_valid high. Throughput is one result per cycle, back-to-back, with no stall and no backpressure.
- rst has priority over in_valid on the same edge.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid result after reset deasserts appears one cycle after the first in_valid sampled with rst = 0.
- REG_OUT=0: y_q = y, out_valid = in_valid, all_equal = &y, match_count = popcount(y), all combinational; rst is ignored.
- Outputs have no X propagation from unused bits. WIDTH=1 yields all_equal == y_q[0].
- Boundary cases:
  - a = b = all ones, or a = b = all zeros -> y all ones, all_equal = 1, match_count = WIDTH.
  - a = ~b -> y = 0, all_equal = 0, match_count = 0.

Optional Feature:
- Macro: XNOR_POPCOUNT_EN.
- Defined: the match_count port exists, with width $clog2(WIDTH+1), or 1 bit when WIDTH=1. It is registered or combinational per REG_OUT, as described above.
- Not defined: the match_count port and the popcount logic are absent. All other behaviour is unchanged.

Test Plan:
- WIDTH=1 combinational truth table: apply a,b = 00, 01, 10, 11, each held 10 time units -> y = 1, 0, 0, 1.
- WIDTH=8, REG_OUT=1: rst high for 2 cycles -> y_q = 0x00, out_valid = 0, all_equal = 0. Then in_valid = 1 with a = 0xA5, b = 0xA5 -> next cycle y_q = 0xFF, all_equal = 1, out_valid = 1, match_count = 8.
- WIDTH=8: back-to-back in_valid with (0xF0, 0x0F), then (0xAA, 0xA0) -> y_q = 0x00 then 0xF5 on consecutive cycles; all_equal = 0 for both; match_count = 0 then 6.
- Hold behaviour: in_valid drops after a result -> out_valid = 0 next cycle; y_q and all_equal keep their last values while a/b change; y still tracks a/b combinationally.
- Reset priority: rst = 1 and in_valid = 1 on the same edge with a = b = 0x3C -> y_q = 0x00, out_valid = 0. The following cycle, with rst = 0 and in_valid = 1 -> out_valid = 1, y_q = 0xFF.
- REG_OUT=0, WIDTH=4: a = 0x9, b = 0x6 with in_valid = 1 -> y_q = 0x0, out_valid = 1, all_equal = 0 in the same timestep, with no clock edge required.

Source files
------------

// File: rtl/xnor_gate_array_if.sv
// Operand/result bundle for xnor_gate_array.
// The slave modport is the unit itself; the master modport is the operand
// source that also observes the results.
// match_count exists only when XNOR_POPCOUNT_EN is defined.
interface xnor_gate_array_if #(
    parameter int WIDTH = 1
);
    localparam int CNT_W = (WIDTH <= 1) ? 1 : $clog2(WIDTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;
    logic             all_equal;
`ifdef XNOR_POPCOUNT_EN
    logic [CNT_W-1:0] match_count;
`endif

    modport master (
        output in_valid, a, b,
        input  y, y_q, out_valid, all_equal
`ifdef XNOR_POPCOUNT_EN
        , input match_count
`endif
    );

    modport slave (
        input  in_valid, a, b,
        output y, y_q, out_valid, all_equal
`ifdef XNOR_POPCOUNT_EN
        , output match_count
`endif
    );
endinterface

// File: rtl/xnor_gate_array.sv
// Bitwise XNOR (equivalence) unit.
// y is always combinational. y_q / out_valid / all_equal (and match_count)
// are flopped when REG_OUT=1, or combinational copies when REG_OUT=0.
// Optional feature macro: XNOR_POPCOUNT_EN adds match_count, the number of
// equal bit positions.
module xnor_gate_array #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    xnor_gate_array_if.slave bus
);
    localparam int CNT_W = (WIDTH <= 1) ? 1 : $clog2(WIDTH + 1);

    logic [WIDTH-1:0] xnor_w;
    logic             all_eq_w;

    assign xnor_w   = ~(bus.a ^ bus.b);
    assign all_eq_w = &xnor_w;
    assign bus.y    = xnor_w;

`ifdef XNOR_POPCOUNT_EN
    logic [CNT_W-1:0] cnt_w;

    // Count equal bit positions of the current operands.
    always_comb begin
        cnt_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_w = cnt_w + CNT_W'(xnor_w[i]);
        end
    end
`endif

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] y_r;
            logic             valid_r;
            logic             eq_r;
`ifdef XNOR_POPCOUNT_EN
            logic [CNT_W-1:0] cnt_r;
`endif

            // Capture on in_valid; reset wins over a same-edge in_valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_r     <= '0;
                    valid_r <= 1'b0;
                    eq_r    <= 1'b0;
`ifdef XNOR_POPCOUNT_EN
                    cnt_r   <= '0;
`endif
                end else begin
                    valid_r <= bus.in_valid;
                    if (bus.in_valid) begin
                        y_r   <= xnor_w;
                        eq_r  <= all_eq_w;
`ifdef XNOR_POPCOUNT_EN
                        cnt_r <= cnt_w;
`endif
                    end
                end
            end

            assign bus.y_q         = y_r;
            assign bus.out_valid   = valid_r;
            assign bus.all_equal   = eq_r;
`ifdef XNOR_POPCOUNT_EN
            assign bus.match_count = cnt_r;
`endif
        end else begin : g_comb
            // Clock and reset play no part in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst  = clk ^ rst;

            assign bus.y_q         = xnor_w;
            assign bus.out_valid   = bus.in_valid;
            assign bus.all_equal   = all_eq_w;
`ifdef XNOR_POPCOUNT_EN
            assign bus.match_count = cnt_w;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_xnor_gate_array.sv
// Bench for xnor_gate_array: WIDTH=1 gate, WIDTH=8 registered, WIDTH=4
// combinational. Directed vector table plus randomized stimulus against a
// per-bit equality model.
module tb_xnor_gate_array;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    xnor_gate_array_if #(.WIDTH(1)) if1 ();
    xnor_gate_array_if #(.WIDTH(8)) if8 ();
    xnor_gate_array_if #(.WIDTH(4)) if4 ();

    xnor_gate_array #(.WIDTH(1), .REG_OUT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    xnor_gate_array #(.WIDTH(8), .REG_OUT(1'b1)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));
    xnor_gate_array #(.WIDTH(4), .REG_OUT(1'b0)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_yq;
        logic       exp_ov;
        logic       exp_eq;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a bit is 1 exactly where the operands agree.
    function automatic logic [7:0] ref_eq(input logic [7:0] a, input logic [7:0] b, input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = (a[i] == b[i]);
        return r;
    endfunction

    function automatic int ref_cnt(input logic [7:0] a, input logic [7:0] b, input int w);
        int c;
        c = 0;
        for (int i = 0; i < w; i++) if (a[i] == b[i]) c++;
        return c;
    endfunction

    logic [7:0] m_yq;
    logic       m_ov;
    logic       m_eq;
    int         m_cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0;

        //          rst   iv    a      b      y_q    ov    eq    cnt
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 8'hA5, 8'hFF, 1'b1, 1'b1, 4'd8};
        vecs[3]  = '{1'b0, 1'b1, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'hAA, 8'hA0, 8'hF5, 1'b1, 1'b0, 4'd6};
        vecs[5]  = '{1'b0, 1'b0, 8'h12, 8'h34, 8'hF5, 1'b0, 1'b0, 4'd6};
        vecs[6]  = '{1'b0, 1'b0, 8'h55, 8'h55, 8'hF5, 1'b0, 1'b0, 4'd6};
        vecs[7]  = '{1'b1, 1'b1, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b0, 1'b1, 8'h3C, 8'h3C, 8'hFF, 1'b1, 1'b1, 4'd8};
        vecs[9]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 4'd8};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 4'd0};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 4'd8};
        vecs[12] = '{1'b1, 1'b1, 8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0, 4'd0};
        vecs[13] = '{1'b0, 1'b0, 8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0, 4'd0};
        vecs[14] = '{1'b0, 1'b1, 8'h0F, 8'h0E, 8'hFE, 1'b1, 1'b0, 4'd7};
        vecs[15] = '{1'b0, 1'b1, 8'h81, 8'h7E, 8'h00, 1'b1, 1'b0, 4'd0};

        // WIDTH=1 truth table, each pair held 10 time units.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            if1.a = ab[1];
            if1.b = ab[0];
            #10;
            chk("w1_truth_y", 64'(if1.y), 64'(ab[1] == ab[0]));
        end

        // WIDTH=8 registered table; inputs change on the falling edge.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            if8.in_valid = vecs[i].iv;
            if8.a        = vecs[i].a;
            if8.b        = vecs[i].b;
            #1;
            chk("w8_y_comb", 64'(if8.y), 64'(ref_eq(vecs[i].a, vecs[i].b, 8)));
            @(posedge clk);
            #1;
            chk("w8_y_q", 64'(if8.y_q), 64'(vecs[i].exp_yq));
            chk("w8_out_valid", 64'(if8.out_valid), 64'(vecs[i].exp_ov));
            chk("w8_all_equal", 64'(if8.all_equal), 64'(vecs[i].exp_eq));
`ifdef XNOR_POPCOUNT_EN
            chk("w8_match_count", 64'(if8.match_count), 64'(vecs[i].exp_cnt));
`endif
        end

        // WIDTH=1 registered: all_equal follows the single result bit.
        @(negedge clk);
        if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0;
        @(posedge clk); #1;
        chk("w1_y_q_diff", 64'(if1.y_q), 64'd0);
        chk("w1_eq_diff", 64'(if1.all_equal), 64'd0);
        @(negedge clk);
        if1.a = 1'b1; if1.b = 1'b1;
        @(posedge clk); #1;
        chk("w1_y_q_same", 64'(if1.y_q), 64'd1);
        chk("w1_eq_same", 64'(if1.all_equal), 64'd1);
        chk("w1_ov", 64'(if1.out_valid), 64'd1);

        // WIDTH=4 combinational: results appear without a clock edge.
        @(negedge clk);
        if4.in_valid = 1'b1; if4.a = 4'h9; if4.b = 4'h6;
        #1;
        chk("w4_y_q", 64'(if4.y_q), 64'h0);
        chk("w4_out_valid", 64'(if4.out_valid), 64'd1);
        chk("w4_all_equal", 64'(if4.all_equal), 64'd0);
        if4.a = 4'h5; if4.b = 4'h5; rst = 1'b1;
        #1;
        chk("w4_y_q_eq", 64'(if4.y_q), 64'hF);
        chk("w4_all_equal_eq", 64'(if4.all_equal), 64'd1);
`ifdef XNOR_POPCOUNT_EN
        chk("w4_match_count", 64'(if4.match_count), 64'd4);
`endif
        if4.in_valid = 1'b0;
        #1;
        chk("w4_out_valid_low", 64'(if4.out_valid), 64'd0);
        rst = 1'b0;

        // Randomized: WIDTH=8 registered against a cycle model, WIDTH=4 comb.
        m_yq = 8'h00; m_ov = 1'b0; m_eq = 1'b0; m_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            logic       r_rst;
            logic       r_iv;
            logic [7:0] r_a;
            logic [7:0] r_b;
            logic [3:0] c_a;
            logic [3:0] c_b;
            r_rst = (i == 0) || ($urandom_range(15) == 0);
            r_iv  = $urandom_range(3) != 0;
            r_a   = 8'($urandom);
            r_b   = ($urandom_range(3) == 0) ? r_a : 8'($urandom);
            if ($urandom_range(7) == 0) r_b = ~r_a;
            c_a   = 4'($urandom);
            c_b   = ($urandom_range(2) == 0) ? c_a : 4'($urandom);
            @(negedge clk);
            rst = r_rst;
            if8.in_valid = r_iv; if8.a = r_a; if8.b = r_b;
            if4.in_valid = r_iv; if4.a = c_a; if4.b = c_b;
            #1;
            chk("rnd_w8_y", 64'(if8.y), 64'(ref_eq(r_a, r_b, 8)));
            chk("rnd_w4_y_q", 64'(if4.y_q), 64'(ref_eq(8'(c_a), 8'(c_b), 4)));
            chk("rnd_w4_eq", 64'(if4.all_equal), 64'(c_a == c_b));
            chk("rnd_w4_ov", 64'(if4.out_valid), 64'(r_iv));
`ifdef XNOR_POPCOUNT_EN
            chk("rnd_w4_cnt", 64'(if4.match_count), 64'(ref_cnt(8'(c_a), 8'(c_b), 4)));
`endif
            if (r_rst) begin
                m_yq = 8'h00; m_ov = 1'b0; m_eq = 1'b0; m_cnt = 0;
            end else if (r_iv) begin
                m_yq = ref_eq(r_a, r_b, 8); m_ov = 1'b1; m_eq = (r_a == r_b);
                m_cnt = ref_cnt(r_a, r_b, 8);
            end else begin
                m_ov = 1'b0;
            end
            @(posedge clk); #1;
            chk("rnd_w8_y_q", 64'(if8.y_q), 64'(m_yq));
            chk("rnd_w8_ov", 64'(if8.out_valid), 64'(m_ov));
            chk("rnd_w8_eq", 64'(if8.all_equal), 64'(m_eq));
`ifdef XNOR_POPCOUNT_EN
            chk("rnd_w8_cnt", 64'(if8.match_count), 64'(m_cnt));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
